// File: rtl/count_step_monitor.sv
// count_step_monitor: checks that each sampled counter step is exactly +/-1, counts wraps and errors, and latches a sticky fault.
// Optional min/max tracking of sampled counts is enabled by defining COUNT_MINMAX_EN.
`default_nettype none

module count_step_monitor #(
    parameter int W         = 5,
    parameter int ERR_LIMIT = 4,
    parameter int WCW       = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           adv,
    input  logic           m,
    input  logic [W-1:0]   count_in,
    input  logic           clr,
    output logic           up_wrap,
    output logic           down_wrap,
    output logic           step_err,
    output logic [WCW-1:0] up_wraps,
    output logic [WCW-1:0] down_wraps,
    output logic [WCW-1:0] err_cnt,
    output logic           fault,
    output logic           synced
`ifdef COUNT_MINMAX_EN
    ,
    output logic [W-1:0]   cnt_min,
    output logic [W-1:0]   cnt_max
`endif
);

    localparam logic [1:0] S_SYNC  = 2'd0;
    localparam logic [1:0] S_TRACK = 2'd1;
    localparam logic [1:0] S_FAULT = 2'd2;

    logic [1:0]     r_state;
    logic [1:0]     w_state_nxt;
    logic [W-1:0]   r_prev_count;
    logic           r_prev_m;
    logic [W-1:0]   w_expected;
    logic           w_check;
    logic           w_err;
    logic           w_up_wrap;
    logic           w_down_wrap;
    logic [WCW-1:0] w_err_inc;
    logic           w_limit;

    function automatic logic [WCW-1:0] sat_inc(input logic [WCW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign w_expected  = r_prev_m ? r_prev_count + 1'b1 : r_prev_count - 1'b1;
    assign w_check     = adv && (r_state == S_TRACK || r_state == S_FAULT);
    assign w_err       = w_check && (count_in != w_expected);
    // Wraps are only credited while tracking; once faulted the wrap statistics freeze.
    assign w_up_wrap   = adv && (r_state == S_TRACK) && (count_in == w_expected)
                         && r_prev_m && (&r_prev_count);
    assign w_down_wrap = adv && (r_state == S_TRACK) && (count_in == w_expected)
                         && !r_prev_m && (r_prev_count == '0);
    assign w_err_inc   = sat_inc(err_cnt);
    assign w_limit     = w_err && (w_err_inc >= WCW'(ERR_LIMIT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_SYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clr) begin
            w_state_nxt = S_SYNC;
        end else begin
            case (r_state)
                S_SYNC:  if (adv) w_state_nxt = S_TRACK;
                S_TRACK: begin
                    if (!adv)        w_state_nxt = S_SYNC;
                    else if (w_limit) w_state_nxt = S_FAULT;
                end
                S_FAULT: w_state_nxt = S_FAULT;
                default: w_state_nxt = S_SYNC;
            endcase
        end
    end

    always_comb begin
        fault  = (r_state == S_FAULT);
        synced = (r_state != S_SYNC);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev_count <= '0;
            r_prev_m     <= 1'b0;
            up_wrap      <= 1'b0;
            down_wrap    <= 1'b0;
            step_err     <= 1'b0;
            up_wraps     <= '0;
            down_wraps   <= '0;
            err_cnt      <= '0;
        end else begin
            if (adv) begin
                r_prev_count <= count_in;
                r_prev_m     <= m;
            end
            if (clr) begin
                up_wrap    <= 1'b0;
                down_wrap  <= 1'b0;
                step_err   <= 1'b0;
                up_wraps   <= '0;
                down_wraps <= '0;
                err_cnt    <= '0;
            end else begin
                up_wrap   <= w_up_wrap;
                down_wrap <= w_down_wrap;
                step_err  <= w_err;
                if (w_up_wrap)   up_wraps   <= sat_inc(up_wraps);
                if (w_down_wrap) down_wraps <= sat_inc(down_wraps);
                if (w_err)       err_cnt    <= w_err_inc;
            end
        end
    end

`ifdef COUNT_MINMAX_EN
    // Reset values make the first sample win both comparisons, so no valid flag is needed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_min <= '1;
            cnt_max <= '0;
        end else if (clr) begin
            cnt_min <= '1;
            cnt_max <= '0;
        end else if (adv) begin
            if (count_in < cnt_min) cnt_min <= count_in;
            if (count_in > cnt_max) cnt_max <= count_in;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_count_step_monitor.sv
// Directed self-checking bench for count_step_monitor (W=5, ERR_LIMIT=4, WCW=8).
`default_nettype none

module tb_count_step_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       adv = 1'b0;
    logic       m   = 1'b0;
    logic [4:0] count_in = '0;
    logic       clr = 1'b0;
    logic       up_wrap, down_wrap, step_err, fault, synced;
    logic [7:0] up_wraps, down_wraps, err_cnt;
`ifdef COUNT_MINMAX_EN
    logic [4:0] cnt_min, cnt_max;
`endif

    int errors = 0;
    int checks = 0;

    count_step_monitor #(.W(5), .ERR_LIMIT(4), .WCW(8)) dut (
        .clk(clk), .rst(rst), .adv(adv), .m(m), .count_in(count_in), .clr(clr),
        .up_wrap(up_wrap), .down_wrap(down_wrap), .step_err(step_err),
        .up_wraps(up_wraps), .down_wraps(down_wraps), .err_cnt(err_cnt),
        .fault(fault), .synced(synced)
`ifdef COUNT_MINMAX_EN
        , .cnt_min(cnt_min), .cnt_max(cnt_max)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one sample at the falling edge; results are visible 1 time unit after the next rising edge.
    task automatic step(input logic a, input logic mm, input logic [4:0] v, input logic c);
        @(negedge clk);
        adv = a; m = mm; count_in = v; clr = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] v;
        int uw_seen;
        int dw_seen;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_synced", synced, 0);
        chk("rst_fault", fault, 0);
        chk("rst_errcnt", err_cnt, 0);
        chk("rst_upwraps", up_wraps, 0);
        @(negedge clk);
        rst = 1'b1;

        // Up sweep 0..31..0
        uw_seen = 0;
        for (int i = 0; i <= 32; i++) begin
            v = 5'(i % 32);
            step(1'b1, 1'b1, v, 1'b0);
            if (up_wrap) uw_seen++;
            chk("up_sweep_err", step_err, 0);
        end
        chk("up_wrap_last", up_wrap, 1);
        chk("up_wrap_count_seen", uw_seen, 1);
        chk("up_wraps", up_wraps, 1);
        chk("up_errcnt", err_cnt, 0);
        chk("up_synced", synced, 1);

        // Idle cycle drops to SYNC, then down sweep 0,31..0
        step(1'b0, 1'b0, 5'd0, 1'b0);
        chk("idle_unsync", synced, 0);
        chk("idle_no_wrap", up_wrap, 0);
        dw_seen = 0;
        for (int i = 0; i <= 32; i++) begin
            v = 5'((32 - i) % 32);
            step(1'b1, 1'b0, v, 1'b0);
            if (down_wrap) dw_seen++;
            if (i == 1) chk("down_wrap_pulse", down_wrap, 1);
            chk("down_sweep_err", step_err, 0);
        end
        chk("down_wrap_seen", dw_seen, 1);
        chk("down_wraps", down_wraps, 1);
        chk("down_keeps_up", up_wraps, 1);
        chk("down_errcnt", err_cnt, 0);

        // 5,6,8 in up mode -> one error, then 9 is legal
        step(1'b0, 1'b1, 5'd0, 1'b0);
        step(1'b1, 1'b1, 5'd5, 1'b0);
        step(1'b1, 1'b1, 5'd6, 1'b0);
        chk("seq_6_ok", step_err, 0);
        step(1'b1, 1'b1, 5'd8, 1'b0);
        chk("seq_8_err", step_err, 1);
        chk("seq_8_errcnt", err_cnt, 1);
        chk("seq_8_fault", fault, 0);
        step(1'b1, 1'b1, 5'd9, 1'b0);
        chk("seq_9_ok", step_err, 0);
        chk("seq_9_errcnt", err_cnt, 1);

        // Clear, then four bad steps reach FAULT
        step(1'b0, 1'b1, 5'd0, 1'b1);
        chk("clr_errcnt", err_cnt, 0);
        chk("clr_upwraps", up_wraps, 0);
        chk("clr_downwraps", down_wraps, 0);
        chk("clr_synced", synced, 0);
        step(1'b1, 1'b1, 5'd10, 1'b0);
        step(1'b1, 1'b1, 5'd20, 1'b0);
        step(1'b1, 1'b1, 5'd25, 1'b0);
        step(1'b1, 1'b1, 5'd2, 1'b0);
        chk("bad3_errcnt", err_cnt, 3);
        chk("bad3_nofault", fault, 0);
        step(1'b1, 1'b1, 5'd7, 1'b0);
        chk("bad4_errcnt", err_cnt, 4);
        chk("bad4_fault", fault, 1);
        chk("bad4_synced", synced, 1);
        step(1'b1, 1'b1, 5'd8, 1'b0);
        chk("fault_legal", step_err, 0);
        step(1'b1, 1'b1, 5'd31, 1'b0);
        chk("fault_still_checks", step_err, 1);
        chk("fault_errcnt5", err_cnt, 5);
        step(1'b1, 1'b1, 5'd0, 1'b0);
        chk("fault_no_upwrap", up_wrap, 0);
        chk("fault_upwraps_frozen", up_wraps, 0);
        chk("fault_wrap_legal", step_err, 0);
        step(1'b0, 1'b1, 5'd0, 1'b0);
        chk("fault_sticky_idle", fault, 1);
        step(1'b0, 1'b1, 5'd0, 1'b1);
        chk("clr_fault", fault, 0);
        chk("clr_fault_errcnt", err_cnt, 0);
        chk("clr_fault_synced", synced, 0);

        // Gap of three idle cycles, resume at 17 without error
        step(1'b1, 1'b1, 5'd3, 1'b0);
        step(1'b1, 1'b1, 5'd4, 1'b0);
        step(1'b1, 1'b1, 5'd5, 1'b0);
        chk("gap_pre_synced", synced, 1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 5'd5, 1'b0);
            chk("gap_unsynced", synced, 0);
        end
        step(1'b1, 1'b1, 5'd17, 1'b0);
        chk("gap_17_noerr", step_err, 0);
        chk("gap_17_synced", synced, 1);
        step(1'b1, 1'b1, 5'd18, 1'b0);
        chk("gap_18_noerr", step_err, 0);
        // clr overrides a simultaneous bad step
        step(1'b1, 1'b1, 5'd2, 1'b1);
        chk("clr_ovr_err", step_err, 0);
        chk("clr_ovr_errcnt", err_cnt, 0);
        chk("clr_ovr_synced", synced, 0);

        // Enter FAULT again, then asynchronous reset mid-cycle
        step(1'b1, 1'b1, 5'd10, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 5'd0, 1'b0);
        chk("refault", fault, 1);
        chk("refault_errcnt", err_cnt, 4);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("arst_fault", fault, 0);
        chk("arst_errcnt", err_cnt, 0);
        chk("arst_synced", synced, 0);
        chk("arst_steperr", step_err, 0);
`ifdef COUNT_MINMAX_EN
        chk("arst_min", cnt_min, 31);
        chk("arst_max", cnt_max, 0);
`endif
        adv = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 1'b1, 5'd3, 1'b0);
        step(1'b1, 1'b1, 5'd4, 1'b0);
        step(1'b1, 1'b1, 5'd5, 1'b0);
        chk("post_rst_noerr", step_err, 0);
        chk("post_rst_synced", synced, 1);
`ifdef COUNT_MINMAX_EN
        chk("mm_min", cnt_min, 3);
        chk("mm_max", cnt_max, 5);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/count_step_monitor.md
Name: count_step_monitor

Overview:
- Downstream checker for the 5-bit up/down counter: samples `count` and mode `m` every clock and verifies each step is exactly ±1 per the mode used.
- Counts up- and down-wraps and flags illegal steps.
- Escalates to a sticky fault state after a programmable number of errors.
- Used in self-checking benches and as an on-chip health monitor for counter chains.

Parameters:
- W, 5, counter width; count range 0..2^W-1.
- ERR_LIMIT, 4, step errors needed to enter FAULT (1..255).
- WCW, 8, width of the wrap and error counters.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-low
- adv  input  1  counter stepped this cycle; 0 = counter held/in reset, no check
- m  input  1  counter mode at this sample; 1 = up, 0 = down
- count_in  input  W  counter value
- clr  input  1  synchronous clear of counters/state
- up_wrap  output  1  one-cycle pulse: legal step 2^W-1 -> 0 with prior m=1
- down_wrap  output  1  one-cycle pulse: legal step 0 -> 2^W-1 with prior m=0
- step_err  output  1  one-cycle pulse: illegal step detected
- up_wraps  output  WCW  saturating up-wrap count
- down_wraps  output  WCW  saturating down-wrap count
- err_cnt  output  WCW  saturating step-error count
- fault  output  1  high while in FAULT
- synced  output  1  high while in TRACK or FAULT

Behaviour:
- Reset (rst=0, async): all outputs 0, state SYNC, internal prev_count=0, prev_m=0.
- Registers: prev_count and prev_m hold the last sample; expected = prev_m ? prev_count+1 : prev_count-1, computed mod 2^W.
- SYNC:
  - adv=1: capture count_in/m, go TRACK, no check.
  - adv=0: stay.
- TRACK, adv=1:
  - count_in==expected: legal; wrap pulse if the step crossed the boundary.
  - otherwise: step_err pulse and err_cnt+1.
  - Always recapture count_in/m.
  - If the post-increment err_cnt reaches ERR_LIMIT, go FAULT.
- TRACK, adv=0: go SYNC; counters retained; no pulse.
- FAULT:
  - fault=1, sticky.
  - Checking continues; step_err and err_cnt update.
  - Wrap pulses and wrap counters frozen.
  - adv=0 does not leave FAULT.
  - Only clr or rst exits.
- clr=1 (sync):
  - Zeroes up_wraps, down_wraps, err_cnt and pulses.
  - State -> SYNC.
  - Overrides any simultaneous error, wrap or FAULT entry that cycle.
- Latency: pulses and counter updates appear the clock edge after the offending sample (1 cycle). All outputs are registered.
- Saturation: counters stop at 2^WCW-1; no wrap.
- m change: uses prev_m, so a direction reversal at sample t is checked against the mode of sample t-1.
- rst mid-sweep: immediate clear, resync on next adv=1.

Optional Feature:
- Macro COUNT_MINMAX_EN.
- Defined: extra outputs cnt_min[W-1:0] and cnt_max[W-1:0].
  - Track min/max count_in over all adv=1 samples since reset/clr.
  - First sample initialises both.
  - Reset values: min=2^W-1, max=0.
  - Cleared by clr.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- rst=0 then release, adv=1, m=1, counter sweeps 0..31..0 (33 samples) -> one up_wrap pulse on the 31->0 sample, up_wraps=1, err_cnt=0, synced=1.
- m=0 sweep from 0 for 33 samples -> one down_wrap on 0->31, down_wraps=1, no errors.
- In TRACK with m=1, feed 5,6,8 -> step_err pulse one cycle after 8, err_cnt=1, fault=0. Next expected value is 9.
- Inject 4 bad steps (ERR_LIMIT=4) -> fault=1 after the 4th. Then drive a legal 31->0 -> no up_wrap, up_wraps unchanged. clr=1 -> fault=0, counters 0, synced=0.
- adv=0 for 3 cycles mid-sweep, then adv=1 at an arbitrary value 17 -> no step_err, synced back to 1 after that sample.
- Assert rst=0 asynchronously mid-cycle during FAULT -> all outputs 0 immediately. With COUNT_MINMAX_EN, feed 3,4,5 -> cnt_min=3, cnt_max=5.
